// File: rtl/regfile_scoreboard.sv
// Integer register file with two combinational read ports, one synchronous write port,
// a per-register busy scoreboard for hazard detection, and a sticky ECALL halt flag.

module regfile_scoreboard #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      NREG     = 32,
    parameter int unsigned      AW       = 5,
    parameter int unsigned      SP_IDX   = 2,
    parameter logic [XLEN-1:0]  SP_INIT  = XLEN'(32'h2ffc),
    parameter int unsigned      HALT_REG = 17,
    parameter int unsigned      HALT_VAL = 10,
    parameter int unsigned      BYPASS   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_dout,
    output logic [XLEN-1:0] rs2_dout,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] rd_din,
    input  logic            write_enable,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            is_ecall,
    output logic            is_halted
);

    localparam bit              BYP       = (BYPASS != 0);
    localparam logic [AW-1:0]   HALT_IDX  = AW'(HALT_REG);
    localparam logic [XLEN-1:0] HALT_WORD = XLEN'(HALT_VAL);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_nxt;
    logic            halted;

    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;

    logic            wr_en;
    logic            fwd1;
    logic            fwd2;
    logic            fwd_a7;
    logic [XLEN-1:0] a7_val;
    logic            halt_req;

    // Architectural write: x0 and a halted machine both drop the commit.
    assign wr_en = write_enable && (rd != '0) && !halted;

    // Same-cycle forwarding hits; never for x0, which reads as zero regardless.
    assign fwd1   = BYP && write_enable && (rd == rs1) && (rs1 != '0);
    assign fwd2   = BYP && write_enable && (rd == rs2) && (rs2 != '0);
    assign fwd_a7 = BYP && write_enable && (rd == HALT_IDX);

    always_comb begin
        rs1_dout = rf[rs1];
        if (rs1 == '0) begin
            rs1_dout = '0;
        end else if (fwd1) begin
            rs1_dout = rd_din;
        end
    end

    always_comb begin
        rs2_dout = rf[rs2];
        if (rs2 == '0) begin
            rs2_dout = '0;
        end else if (fwd2) begin
            rs2_dout = rd_din;
        end
    end

    // A producer committing this cycle no longer counts as outstanding when its data is forwarded.
    assign rs1_busy = busy_q[rs1] && !fwd1;
    assign rs2_busy = busy_q[rs2] && !fwd2;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf[AW'(i)] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (wr_en) begin
            rf[rd] <= rd_din;
        end
    end

    // Issue sets after commit clears, so a new producer to the same index wins.
    always_comb begin
        busy_nxt = busy_q;
        if (!halted) begin
            if (write_enable && (rd != '0)) begin
                busy_nxt[rd] = 1'b0;
            end
            if (issue_valid && (issue_rd != '0)) begin
                busy_nxt[issue_rd] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    // Halt compares the forwarded a7 value so a same-cycle write to a7 is honoured.
    assign a7_val   = (HALT_IDX == '0) ? '0 : (fwd_a7 ? rd_din : rf[HALT_IDX]);
    assign halt_req = is_ecall && (a7_val == HALT_WORD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_RUN:   if (halt_req) state_nxt = S_HALT;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        halted    = 1'b0;
        is_halted = 1'b0;
        if (state_q == S_HALT) begin
            halted    = 1'b1;
            is_halted = 1'b1;
        end
    end

endmodule
